// File: rtl/meta_evt_counters.sv
// meta_evt_counters: bank of saturating per-event statistics counters with a
// 4-phase read handshake and optional clear-on-read.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   evt       - single-cycle event pulses, one per counter
//   rd_req    - read request, held high until rd_ack is seen
//   rd_addr   - counter index, stable while rd_req is high
//   clr_on_rd - sampled with rd_req; clears the addressed counter and its ovf flag
//   rd_ack    - one-cycle acknowledge; rd_data is valid in the same cycle
//   rd_data   - snapshot of the addressed counter (0 for out-of-range addresses)
//   ovf       - sticky saturation flags, one per counter
module meta_evt_counters #(
  parameter int unsigned NUM_EVT   = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned AWIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_EVT-1:0]   evt,
  input  logic                 rd_req,
  input  logic [AWIDTH-1:0]    rd_addr,
  input  logic                 clr_on_rd,
  output logic                 rd_ack,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [NUM_EVT-1:0]   ovf
);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e               state_q;
  logic                 rd_ack_q;
  logic [CNT_WIDTH-1:0] rd_data_q;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_EVT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_EVT];
  logic [NUM_EVT-1:0]   ovf_q, ovf_d;

  logic                 sample;
  logic [NUM_EVT-1:0]   addr_hit;
  logic [CNT_WIDTH-1:0] snap;

  // A read is taken only from idle, so a held rd_req never re-samples.
  assign sample = (state_q == StIdle) && rd_req;

  // Address decode and snapshot mux; an address with no matching counter
  // leaves addr_hit empty and snap at zero.
  always_comb begin
    addr_hit = '0;
    snap     = '0;
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      if (rd_addr == AWIDTH'(i)) begin
        addr_hit[i] = 1'b1;
        snap        = cnt_q[i];
      end
    end
  end

  // Counter next state. A clear that coincides with an event restarts the
  // counter at 1 so that event is not lost.
  always_comb begin
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (sample && clr_on_rd && addr_hit[i]) begin
        cnt_d[i] = evt[i] ? CNT_WIDTH'(1) : '0;
        ovf_d[i] = 1'b0;
      end else if (evt[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Read handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_req) begin
            rd_data_q <= snap;
            rd_ack_q  <= 1'b1;
            state_q   <= StAck;
          end
        end
        StAck: begin
          rd_ack_q <= 1'b0;
          state_q  <= StWait;
        end
        StWait: begin
          if (!rd_req) begin
            state_q <= StIdle;
          end
        end
        default: begin
          rd_ack_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_meta_evt_counters.sv
// Testbench for meta_evt_counters: directed scenarios followed by random
// events and reads, checked against a counting model through a scoreboard.
module tb_meta_evt_counters;

  localparam int NEVT = 4;
  localparam int CW   = 4;
  localparam int AW   = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NEVT-1:0] evt = '0;
  logic            rd_req = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            clr_on_rd = 1'b0;
  logic            rd_ack;
  logic [CW-1:0]   rd_data;
  logic [NEVT-1:0] ovf;

  meta_evt_counters #(
    .NUM_EVT  (NEVT),
    .CNT_WIDTH(CW),
    .AWIDTH   (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .evt      (evt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .clr_on_rd(clr_on_rd),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int cyc;} exp_t;
  typedef struct {bit chk; int val;} cst_t;

  exp_t exp_q[$];
  cst_t cst_q[$];

  // Driver-owned
  int req_seq = 0;
  int tmo_cnt = 0;
  bit done = 1'b0;

  // Model-owned
  int              done_seq = 0;
  int              cyc = 0;
  bit              rst_seen = 1'b0;
  int              m_cnt[NEVT];
  logic [NEVT-1:0] m_ovf = '0;

  // Monitor-owned
  int vectors = 0;
  int miscompares = 0;
  bit fin = 1'b0;

  // Reference model: counts events per index with saturation, takes one
  // snapshot per request the driver issues, on the edge after it is raised.
  always @(posedge clk) begin
    int clr_idx;
    int a;
    cyc = cyc + 1;
    rst_seen = reset;
    if (reset) begin
      for (int i = 0; i < NEVT; i++) m_cnt[i] = 0;
      m_ovf = '0;
      done_seq = req_seq;
    end else begin
      clr_idx = -1;
      if (done_seq != req_seq) begin
        done_seq = req_seq;
        a = int'(rd_addr);
        exp_q.push_back('{(a < NEVT) ? m_cnt[a] : 0, cyc});
        if (clr_on_rd && a < NEVT) clr_idx = a;
      end
      for (int i = 0; i < NEVT; i++) begin
        if (i == clr_idx) begin
          m_cnt[i] = evt[i] ? 1 : 0;
          m_ovf[i] = 1'b0;
        end else if (evt[i]) begin
          if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  // Monitor: compares every ack against the scoreboard, flags every cycle.
  always @(negedge clk) begin
    exp_t e;
    cst_t c;
    if (cyc >= 1 && !fin) begin
      if (rd_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack_unexpected: rd_ack=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (int'(rd_data) != e.data) begin
            miscompares++;
            $display("FAIL rd_data: got %0d, required %0d (cycle %0d)", rd_data, e.data, cyc);
          end
          vectors++;
          if (cyc != e.cyc) begin
            miscompares++;
            $display("FAIL ack_latency: ack at cycle %0d, required %0d", cyc, e.cyc);
          end
          if (cst_q.size() != 0) begin
            c = cst_q.pop_front();
            if (c.chk) begin
              vectors++;
              if (int'(rd_data) != c.val) begin
                miscompares++;
                $display("FAIL rd_data_directed: got %0d, required %0d", rd_data, c.val);
              end
            end
          end
        end
      end
      vectors++;
      if (ovf !== m_ovf) begin
        miscompares++;
        $display("FAIL ovf: got %b, required %b (cycle %0d)", ovf, m_ovf, cyc);
      end
      if (rst_seen) begin
        vectors++;
        if (rd_ack !== 1'b0 || rd_data !== '0) begin
          miscompares++;
          $display("FAIL reset_outputs: rd_ack=%b rd_data=%0d, required 0/0", rd_ack, rd_data);
        end
      end
      if (done) begin
        fin = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL missing_acks: %0d outstanding, required 0", exp_q.size());
        end
        vectors++;
        if (tmo_cnt != 0) begin
          miscompares++;
          $display("FAIL ack_timeout: %0d reads never acked, required 0", tmo_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [NEVT-1:0] rand_evt();
    logic [NEVT-1:0] r;
    for (int i = 0; i < NEVT; i++) r[i] = ($urandom_range(0, 99) < 30);
    return r;
  endfunction

  task automatic tick(input logic [NEVT-1:0] e);
    evt = e;
    @(posedge clk);
    #1;
    evt = '0;
  endtask

  // Full read transaction. e0 is the event vector in the sampling cycle.
  task automatic do_read(input int addr, input bit clr, input logic [NEVT-1:0] e0,
                         input bit chk, input int val, input bit rnd, input int hold);
    bit got;
    cst_q.push_back('{chk, val});
    rd_req    = 1'b1;
    rd_addr   = AW'(addr);
    clr_on_rd = clr;
    req_seq++;
    tick(e0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (rd_ack === 1'b1) got = 1'b1;
      else tick(rnd ? rand_evt() : '0);
    end
    if (!got) tmo_cnt++;
    for (int k = 0; k < hold; k++) tick(rnd ? rand_evt() : '0);
    rd_req    = 1'b0;
    clr_on_rd = 1'b0;
    tick(rnd ? rand_evt() : '0);
    tick(rnd ? rand_evt() : '0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) tick('0);
    reset = 1'b0;
    tick('0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    // Basic counting
    for (int k = 0; k < 5; k++) begin tick(4'b0001); tick('0); end
    for (int k = 0; k < 3; k++) tick(4'b0100);
    do_read(0, 1'b0, '0, 1'b1, 5, 1'b0, 0);
    do_read(2, 1'b0, '0, 1'b1, 3, 1'b0, 0);

    // Held request gives a single ack
    do_read(1, 1'b0, '0, 1'b1, 0, 1'b0, 9);

    // Clear-on-read with a coincident event
    tick(4'b0001);
    tick(4'b0001);
    do_read(0, 1'b1, 4'b0001, 1'b1, 7, 1'b0, 0);
    do_read(0, 1'b0, '0, 1'b1, 1, 1'b0, 0);

    // Saturation and overflow clear
    for (int k = 0; k < 17; k++) tick(4'b1000);
    do_read(3, 1'b0, '0, 1'b1, MAXV, 1'b0, 0);
    do_read(3, 1'b1, '0, 1'b1, MAXV, 1'b0, 0);
    do_read(3, 1'b0, '0, 1'b1, 0, 1'b0, 0);

    // Simultaneous events and out-of-range addresses
    do_reset(2);
    for (int k = 0; k < 4; k++) tick(4'b1111);
    do_read(5, 1'b1, '0, 1'b1, 0, 1'b0, 0);
    do_read(4, 1'b0, '0, 1'b1, 0, 1'b0, 0);
    do_read(7, 1'b1, '0, 1'b1, 0, 1'b0, 0);
    for (int a = 0; a < NEVT; a++) do_read(a, 1'b0, '0, 1'b1, 4, 1'b0, 0);

    // Reset during the ack cycle
    tick(4'b0110);
    cst_q.push_back('{1'b0, 0});
    rd_req  = 1'b1;
    rd_addr = AW'(2);
    req_seq++;
    tick('0);
    reset  = 1'b1;
    rd_req = 1'b0;
    tick('0);
    reset = 1'b0;
    tick('0);
    for (int a = 0; a < NEVT; a++) do_read(a, 1'b0, '0, 1'b1, 0, 1'b0, 0);

    // Random traffic
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_read(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), rand_evt(),
                1'b0, 0, 1'b1, int'($urandom_range(0, 3)));
      end else begin
        tick(rand_evt());
      end
    end

    tick('0);
    done = 1'b1;
  end

endmodule
